// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative shift-add multiply
// and restoring divide, with a registered result held under a valid/ready handshake.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SH_W  = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [5:0]       operation,
   input  logic [SH_W-1:0]  shift_amount,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             div_zero,
   output logic             illegal
);
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

   localparam logic [SH_W:0]    LAST_STEP = (SH_W+1)'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ALL_ZERO  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};

   state_t           state_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             rem_sel_r;
   logic [SH_W:0]    cnt_r;

   logic             accept_s;
   logic [WIDTH-1:0] imm_res_s;
   logic             imm_dz_s;
   logic             imm_il_s;
   logic             go_mul_s;
   logic             go_div_s;
   logic [WIDTH-1:0] mul_sum_s;
   logic [WIDTH:0]   div_part_s;
   logic [WIDTH:0]   div_diff_s;
   logic             div_ge_s;
   logic [WIDTH-1:0] div_rem_s;
   logic [WIDTH-1:0] div_quo_s;
   logic [WIDTH-1:0] div_res_s;

   assign in_ready = (state_r == IDLE) | ((state_r == DONE) & out_ready);
   assign accept_s = in_valid & in_ready;

   // Decode of the single-cycle operations and selection of the iterative paths
   always_comb begin
      imm_res_s = ALL_ZERO;
      imm_dz_s  = 1'b0;
      imm_il_s  = 1'b0;
      go_mul_s  = 1'b0;
      go_div_s  = 1'b0;
      case (operation)
         6'd0:  imm_res_s = op1 + op2;
         6'd1:  imm_res_s = op1 - op2;
         6'd2:  go_mul_s = 1'b1;
         6'd3: begin
            if (op2 == ALL_ZERO) begin
               imm_res_s = ALL_ONES;
               imm_dz_s  = 1'b1;
            end else begin
               go_div_s = 1'b1;
            end
         end
         6'd4:  imm_res_s = op2 << shift_amount;
         6'd5:  imm_res_s = op2 >> shift_amount;
         6'd6:  imm_res_s = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
         6'd7:  imm_res_s = op1 & op2;
         6'd8:  imm_res_s = op1 | op2;
         6'd9:  imm_res_s = op1 ^ op2;
         6'd10: imm_res_s = ~(op1 | op2);
         6'd11: imm_res_s = $unsigned($signed(op2) >>> shift_amount);
         6'd12: imm_res_s = op2 << 5'd16;
         6'd13: imm_res_s = {{(WIDTH-1){1'b0}}, (op1 < op2)};
         6'd14: begin
            if (op2 == ALL_ZERO) begin
               imm_res_s = op1;
               imm_dz_s  = 1'b1;
            end else begin
               go_div_s = 1'b1;
            end
         end
         default: imm_il_s = 1'b1;
      endcase
   end

   // One shift-add multiply step and one restoring-divide step per cycle
   always_comb begin
      if (b_r[0]) begin
         mul_sum_s = acc_r + a_r;
      end else begin
         mul_sum_s = acc_r;
      end
      div_part_s = {acc_r, a_r[WIDTH-1]};
      div_diff_s = div_part_s - {1'b0, b_r};
      div_ge_s   = ~div_diff_s[WIDTH];
      if (div_ge_s) begin
         div_rem_s = div_diff_s[WIDTH-1:0];
      end else begin
         div_rem_s = div_part_s[WIDTH-1:0];
      end
      div_quo_s = {a_r[WIDTH-2:0], div_ge_s};
      if (rem_sel_r) begin
         div_res_s = div_rem_s;
      end else begin
         div_res_s = div_quo_s;
      end
   end

   // Control FSM with registered result, flags and valid
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         out_valid <= 1'b0;
         result    <= ALL_ZERO;
         zero      <= 1'b0;
         div_zero  <= 1'b0;
         illegal   <= 1'b0;
         cnt_r     <= {(SH_W+1){1'b0}};
         acc_r     <= ALL_ZERO;
         a_r       <= ALL_ZERO;
         b_r       <= ALL_ZERO;
         rem_sel_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (accept_s) begin
                  cnt_r     <= {(SH_W+1){1'b0}};
                  acc_r     <= ALL_ZERO;
                  a_r       <= op1;
                  b_r       <= op2;
                  rem_sel_r <= (operation == 6'd14);
                  if (go_mul_s) begin
                     state_r   <= MUL;
                     out_valid <= 1'b0;
                  end else if (go_div_s) begin
                     state_r   <= DIV;
                     out_valid <= 1'b0;
                  end else begin
                     state_r   <= DONE;
                     out_valid <= 1'b1;
                     result    <= imm_res_s;
                     zero      <= (imm_res_s == ALL_ZERO);
                     div_zero  <= imm_dz_s;
                     illegal   <= imm_il_s;
                  end
               end else if ((state_r == DONE) && out_ready) begin
                  state_r   <= IDLE;
                  out_valid <= 1'b0;
               end else begin
                  state_r <= state_r;
               end
            end
            MUL: begin
               acc_r <= mul_sum_s;
               a_r   <= a_r << 1;
               b_r   <= b_r >> 1;
               cnt_r <= cnt_r + 1'b1;
               if (cnt_r == LAST_STEP) begin
                  state_r   <= DONE;
                  out_valid <= 1'b1;
                  result    <= mul_sum_s;
                  zero      <= (mul_sum_s == ALL_ZERO);
                  div_zero  <= 1'b0;
                  illegal   <= 1'b0;
               end else begin
                  state_r <= MUL;
               end
            end
            DIV: begin
               acc_r <= div_rem_s;
               a_r   <= div_quo_s;
               cnt_r <= cnt_r + 1'b1;
               if (cnt_r == LAST_STEP) begin
                  state_r   <= DONE;
                  out_valid <= 1'b1;
                  result    <= div_res_s;
                  zero      <= (div_res_s == ALL_ZERO);
                  div_zero  <= 1'b0;
                  illegal   <= 1'b0;
               end else begin
                  state_r <= DIV;
               end
            end
            default: begin
               state_r   <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule
